// File: rtl/sid_sequencer.sv
// Slot scheduler for the SID voice/filter pipeline. It starts a 21-clk frame on each
// falling edge of phi2 and generates the ~1 kHz tick and a sticky overrun flag.
module sid_sequencer #(
    parameter int SYNC_STAGES = 0,
    parameter int US_BITS     = 10
) (
    input  logic       clk,
    input  logic       res,
    input  logic       phi2,
    input  logic       clr_overrun,
    output logic [3:0] voice_cycle,
    output logic [3:0] filter_cycle,
    output logic       voice_idle,
    output logic       busy,
    output logic       tick_ms,
    output logic       overrun
);

    logic               phi2_s;
    logic               phi2_prev;
    logic               fall;
    logic [3:0]         vcount;
    logic [US_BITS-1:0] us_cnt;
    logic               v_adv;
    logic               f_adv;
    logic               us_inc;
    logic               us_wrap;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign phi2_s = phi2;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk) begin
                if (res) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= phi2;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign phi2_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // The voice count is frozen, not cleared, while the filter owns the shared slots,
    // so busy stays high across the pauses.
    always_comb begin
        fall         = phi2_prev & ~phi2_s;
        voice_idle   = filter_cycle inside {4'd4, 4'd5, 4'd9, 4'd10};
        voice_cycle  = voice_idle ? 4'd0 : vcount;
        busy         = (vcount != 4'd0) | (filter_cycle != 4'd0);
        v_adv        = (fall & ~busy) | ((vcount != 4'd0) & ~voice_idle);
        f_adv        = (voice_cycle == 4'd6) | (filter_cycle != 4'd0);
        us_inc       = (voice_cycle == 4'd1);
        us_wrap      = us_inc & (us_cnt == {US_BITS{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (res) begin
            phi2_prev    <= 1'b0;
            vcount       <= 4'd0;
            filter_cycle <= 4'd0;
            us_cnt       <= '0;
            tick_ms      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            phi2_prev <= phi2_s;
            if (v_adv) begin
                vcount <= vcount + 4'd1;
            end
            if (f_adv) begin
                filter_cycle <= filter_cycle + 4'd1;
            end
            if (us_inc) begin
                us_cnt <= us_cnt + 1'b1;
            end
            tick_ms <= us_wrap;
            // A fresh overrun event beats a simultaneous clear.
            if (fall & busy) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sid_sequencer.sv
// Self-checking bench for sid_sequencer: frame slot sequence, overrun handling,
// mid-frame reset, phi2 synchronizer latency and the tick_ms period.
module tb_sid_sequencer;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       phi2 = 1'b1;
    logic       phi2_b = 1'b1;
    logic       clr_overrun = 1'b0;

    logic [3:0] voice_cycle, filter_cycle;
    logic       voice_idle, busy, tick_ms, overrun;
    logic [3:0] voice_cycle_b, filter_cycle_b;
    logic       voice_idle_b, busy_b, tick_ms_b, overrun_b;

    int checks = 0;
    int failures = 0;

    logic [10:0] exp_q[$];
    logic [31:0] tick_q[$];

    sid_sequencer #(.SYNC_STAGES(0), .US_BITS(10)) dut (
        .clk(clk), .res(res), .phi2(phi2), .clr_overrun(clr_overrun),
        .voice_cycle(voice_cycle), .filter_cycle(filter_cycle),
        .voice_idle(voice_idle), .busy(busy), .tick_ms(tick_ms), .overrun(overrun)
    );

    sid_sequencer #(.SYNC_STAGES(2), .US_BITS(10)) dut_sync (
        .clk(clk), .res(res), .phi2(phi2_b), .clr_overrun(clr_overrun),
        .voice_cycle(voice_cycle_b), .filter_cycle(filter_cycle_b),
        .voice_idle(voice_idle_b), .busy(busy_b), .tick_ms(tick_ms_b), .overrun(overrun_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {overrun, busy, voice_idle, voice_cycle, filter_cycle} in frame clk k.
    function automatic logic [10:0] exp_slot(input int k, input int inject_k);
        logic [3:0] v, f;
        logic       idle, bsy, ovr;
        f = (k >= 7 && k <= 21) ? 4'(k - 6) : 4'd0;
        if (k <= 9)                 v = 4'(k);
        else if (k >= 12 && k <= 14) v = 4'(k - 2);
        else if (k >= 17 && k <= 19) v = 4'(k - 4);
        else                         v = 4'd0;
        idle = (k == 10 || k == 11 || k == 15 || k == 16);
        bsy  = (k <= 21);
        ovr  = (inject_k > 0 && k > inject_k);
        return {ovr, bsy, idle, v, f};
    endfunction

    task automatic run_frame(input int inject_k, input int stop_k);
        logic [10:0] exp_val, got;
        phi2 = 1'b1;
        tick();
        phi2 = 1'b0;
        for (int k = 1; k <= 22; k++) exp_q.push_back(exp_slot(k, inject_k));
        for (int k = 1; k <= 22; k++) begin
            tick();
            exp_val = exp_q.pop_front();
            got = {overrun, busy, voice_idle, voice_cycle, filter_cycle};
            checks++;
            if (got !== exp_val) begin
                failures++;
                $display("FAIL frame_slot k=%0d inject=%0d got ovr/busy/idle/v/f=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                         k, inject_k, got[10], got[9], got[8], got[7:4], got[3:0],
                         exp_val[10], exp_val[9], exp_val[8], exp_val[7:4], exp_val[3:0]);
            end
            if (k == 1) phi2 = 1'b1;
            if (k == inject_k) phi2 = 1'b0;
            if (k == inject_k + 1) phi2 = 1'b1;
            if (k == stop_k) begin
                exp_q.delete();
                break;
            end
        end
    endtask

    task automatic test_reset();
        res = 1'b1;
        phi2 = 1'b0;
        phi2_b = 1'b0;
        tick();
        tick();
        res = 1'b0;
        checks++;
        if ({tick_ms, overrun, busy, voice_idle, voice_cycle, filter_cycle} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0d f=%0d busy=%b idle=%b tick=%b ovr=%b expected all 0",
                     voice_cycle, filter_cycle, busy, voice_idle, tick_ms, overrun);
        end
        checks++;
        if ({tick_ms_b, overrun_b, busy_b, voice_idle_b, voice_cycle_b, filter_cycle_b} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs_sync got v=%0d f=%0d busy=%b expected all 0",
                     voice_cycle_b, filter_cycle_b, busy_b);
        end
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL no_spurious_edge got busy=%b busy_b=%b expected 0/0", busy, busy_b);
        end
        phi2 = 1'b1;
        phi2_b = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        run_frame(0, 22);
    endtask

    task automatic test_overrun();
        run_frame(10, 22);
        tick();
        tick();
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky got %b expected 1", overrun);
        end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear got %b expected 0", overrun);
        end
    endtask

    task automatic test_clr_collision();
        phi2 = 1'b1;
        tick();
        phi2 = 1'b0;
        tick();
        phi2 = 1'b1;
        tick();
        phi2 = 1'b0;
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        phi2 = 1'b1;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL clr_vs_set got overrun=%b expected 1", overrun);
        end
        for (int i = 0; i < 25; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL collision_frame_end got busy=%b expected 0", busy);
        end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        run_frame(0, 13);
        res = 1'b1;
        tick();
        res = 1'b0;
        checks++;
        if ({tick_ms, overrun, busy, voice_idle, voice_cycle, filter_cycle} !== 12'd0) begin
            failures++;
            $display("FAIL mid_frame_reset got v=%0d f=%0d busy=%b idle=%b expected all 0",
                     voice_cycle, filter_cycle, busy, voice_idle);
        end
        tick();
        run_frame(0, 22);
    endtask

    task automatic test_sync_latency();
        int lat0, lat2, cnt;
        lat0 = 0;
        lat2 = 0;
        phi2 = 1'b1;
        phi2_b = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        phi2 = 1'b0;
        phi2_b = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (lat0 == 0 && voice_cycle == 4'd1) lat0 = c;
            if (lat2 == 0 && voice_cycle_b == 4'd1) lat2 = c;
        end
        checks++;
        if (lat0 !== 1) begin
            failures++;
            $display("FAIL latency_sync0 got %0d clk expected 1", lat0);
        end
        checks++;
        if (lat2 !== 3) begin
            failures++;
            $display("FAIL latency_sync2 got %0d clk expected 3", lat2);
        end
        phi2 = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy_b !== 1'b0) cnt++;
        end
        checks++;
        if (cnt !== 0) begin
            failures++;
            $display("FAIL held_low_no_frame got %0d busy clk expected 0", cnt);
        end
        phi2_b = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy_b !== 1'b0) cnt++;
        end
        checks++;
        if (cnt !== 0) begin
            failures++;
            $display("FAIL held_high_no_frame got %0d busy clk expected 0", cnt);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic [31:0] exp_val, got;
        pulses = 0;
        phi2 = 1'b1;
        res = 1'b1;
        tick();
        res = 1'b0;
        tick();
        tick_q.push_back(32'd1024 * 32 + 2);
        tick_q.push_back(32'd2048 * 32 + 2);
        for (int f = 1; f <= 2048; f++) begin
            phi2 = 1'b0;
            for (int k = 1; k <= 22; k++) begin
                tick();
                if (k == 1) phi2 = 1'b1;
                if (tick_ms === 1'b1) begin
                    pulses++;
                    got = 32'(f * 32 + k);
                    checks++;
                    if (tick_q.size() == 0) begin
                        failures++;
                        $display("FAIL tick_ms_extra pulse at frame %0d clk %0d expected none", f, k);
                    end else begin
                        exp_val = tick_q.pop_front();
                        if (got !== exp_val) begin
                            failures++;
                            $display("FAIL tick_ms_position got frame %0d clk %0d expected frame %0d clk %0d",
                                     f, k, exp_val / 32, exp_val % 32);
                        end
                    end
                end
            end
        end
        checks++;
        if (pulses !== 2) begin
            failures++;
            $display("FAIL tick_ms_count got %0d expected 2", pulses);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_overrun got %b expected 0", overrun);
        end
        tick_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overrun();
        test_clr_collision();
        test_reset_mid_frame();
        test_sync_latency();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sid_sequencer.md
Name: sid_sequencer

Overview:
Central cycle scheduler for the SID voice/filter pipeline. Detects the falling edge of phi2 and issues the voice_cycle and filter_cycle slot numbers that sid_control, sid_waveform, sid_envelope, sid_voice, sid_filter and sid_pot use to time-share their datapaths. It pauses the voice pipeline while the filter pipeline handles EXT IN / output slots, and generates the ~1 kHz tick_ms. It also flags phi2 edges that arrive while a frame is still in flight.

Parameters:
SYNC_STAGES, 0, phi2 synchronizer flops ahead of the edge detector (0 = phi2 used directly); adds SYNC_STAGES clk of latency.
US_BITS, 10, width of the phi2-frame counter; tick_ms period = 2^US_BITS frames.

Ports:
clk  input  1  system clock
res  input  1  synchronous reset, active-high
phi2  input  1  bus phi2 (~1 MHz)
clr_overrun  input  1  clears sticky overrun flag
voice_cycle  output  4  voice slot number, 0 = idle/paused
filter_cycle  output  4  filter slot number, 0 = idle
voice_idle  output  1  voice pipeline paused this clk
busy  output  1  voice count != 0 or filter_cycle != 0
tick_ms  output  1  one-clk pulse every 2^US_BITS frames
overrun  output  1  sticky: phi2 falling edge arrived while busy

Behaviour:
- Reset (res=1 at clk edge): voice count, filter_cycle, us counter, phi2 sync flops and phi2_prev all go to 0; tick_ms=0, overrun=0; voice_cycle=0, busy=0. A reset mid-frame aborts the frame immediately; there is no resume. phi2_prev=0 means no spurious edge after reset.
- Edge detect: fall = phi2_prev & ~phi2_s, where phi2_s is phi2 after SYNC_STAGES flops. phi2_prev <= phi2_s every clk.
- voice_idle (combinational) = filter_cycle ∈ {4,5,9,10}.
- voice_cycle (combinational) = voice_idle ? 0 : vcount.
- vcount (4-bit) advances under either condition:
  - fall & !busy: +1, which starts a frame.
  - vcount != 0 & !voice_idle: +1.
  - Otherwise vcount holds. It wraps 15->0, ending the voice frame.
- filter_cycle (4-bit) advances +1 when voice_cycle == 6 or filter_cycle != 0. It wraps 15->0.
- Frame timing, with fall seen at clk t0 (v = voice_cycle, f = filter_cycle):
  - t1..t6: v=1..6, f=0.
  - t7..t9: v=7..9, f=1..3.
  - t10..t11: v=0 (paused), f=4,5.
  - t12..t14: v=10..12, f=6..8.
  - t15..t16: v=0, f=9,10.
  - t17..t19: v=13..15, f=11..13.
  - t20..t21: v=0, f=14,15.
  - t22: both 0, busy=0.
  - A frame occupies 21 clk; a new fall is accepted from t22 onward.
- Overrun: if fall occurs while busy=1, the edge is ignored (no restart, no count perturbation) and overrun <= 1. The flag stays set until res or clr_overrun.
  - If clr_overrun and a new overrun event coincide, set wins.
- tick_ms: the us counter (US_BITS) increments when voice_cycle == 1. tick_ms is registered and is 1 for exactly the clk following the increment that wraps the counter from all-ones to 0; otherwise 0.
- busy = (vcount != 0) | (filter_cycle != 0). vcount is held at non-zero during pauses, so busy stays 1 through them.
- Pure control block; no datapath arithmetic beyond the 4-bit and US_BITS counters.

Test Plan:
- Reset then a single phi2 1->0 edge (SYNC_STAGES=0) -> voice_cycle sequence 1..9,0,0,10..12,0,0,13..15,0,0,0; filter_cycle 0×6 then 1..15 then 0; busy high exactly 21 clk; overrun=0.
- Second phi2 fall injected at frame clk t10 (pause slot) -> sequence identical to a clean frame; overrun=1 at t11 and stays 1 until clr_overrun, then 0 next clk.
- Back-to-back falls 22 clk apart for 2048 frames, US_BITS=10 -> tick_ms pulses exactly twice, each 1 clk wide, following frames 1024 and 2048; overrun stays 0.
- res asserted at frame clk t13 (v=11, f=7) -> next clk all outputs 0; a phi2 fall 2 clk later starts a clean frame at voice_cycle=1.
- SYNC_STAGES=2, phi2 fall -> voice_cycle=1 appears 2 clk later than the SYNC_STAGES=0 case; phi2 held low or high continuously -> no frame starts.
- clr_overrun and an overrun-causing fall in the same clk -> overrun=1.
